// File: rtl/sseg_pkg.sv
// sseg_pkg: segment patterns and FSM encoding shared by the signed seven-segment driver.
// Rev 1.0
`default_nettype none

package sseg_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_E     = 7'h79;

  // Patterns are {g,f,e,d,c,b,a}, active-high.
  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = SEG_BLANK;
    endcase
    return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sseg_encode.sv
// sseg_encode: one digit position -> seven-segment pattern (error > minus > blank > digit).
// Rev 1.0
`default_nettype none

module sseg_encode
  import sseg_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  input  logic       i_minus,
  input  logic       i_error,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (i_error)      o_seg = SEG_E;
    else if (i_minus) o_seg = SEG_MINUS;
    else if (i_blank) o_seg = SEG_BLANK;
    else              o_seg = seg_digit(i_digit);
  end

endmodule

`default_nettype wire

// File: rtl/snum_sseg_driver.sv
// snum_sseg_driver: signed binary to blanked decimal seven-segment display, one digit per cycle.
// Rev 1.0
`default_nettype none

module snum_sseg_driver
  import sseg_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  input  logic                  display_en,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   segs
);

  localparam int CNT_W = $clog2(DIGITS);

  state_t              r_state;
  state_t              w_next;
  logic                r_neg;
  logic [WIDTH-1:0]    r_mag;
  logic [CNT_W-1:0]    r_cnt;
  logic [3:0]          r_dig [DIGITS];
  logic [7*DIGITS-1:0] r_segs;
  logic                r_overflow;
  logic                r_done;

  logic                w_last;
  logic [WIDTH-1:0]    w_abs;
  logic [WIDTH-1:0]    w_quot;
  logic [3:0]          w_rem;
  logic                w_ov;
  logic [3:0]          w_dig [DIGITS];
  logic [DIGITS-1:0]   w_blank;
  logic [DIGITS-1:0]   w_minus;
  logic [DIGITS-1:0]   w_error;
  logic [7*DIGITS-1:0] w_seg_new;

  // Unsigned magnitude keeps -2^(WIDTH-1) exact.
  assign w_abs  = value[WIDTH-1] ? (~value + WIDTH'(1)) : value;
  assign w_quot = r_mag / WIDTH'(10);
  assign w_rem  = 4'(r_mag % WIDTH'(10));
  assign w_last = (r_cnt == CNT_W'(DIGITS-1));

  // On the commit cycle w_rem is the top digit and w_quot what is left beyond it.
  assign w_ov = r_neg ? ((w_quot != '0) || (w_rem != 4'd0)) : (w_quot != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_next = ST_CONV;
      ST_CONV: if (w_last) w_next = ST_IDLE;
      default:             w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    int msd;
    msd = 0;
    for (int i = 0; i < DIGITS; i++) begin
      w_dig[i] = (CNT_W'(i) == r_cnt) ? w_rem : r_dig[i];
      if (w_dig[i] != 4'd0) msd = i;
    end
    for (int i = 0; i < DIGITS; i++) begin
      w_error[i] = w_ov && (i == 0);
      w_minus[i] = !w_ov && r_neg && (i == msd + 1);
      w_blank[i] = w_ov ? (i != 0) : (i > msd);
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_enc
    sseg_encode u_enc (
      .i_digit (w_dig[g]),
      .i_blank (w_blank[g]),
      .i_minus (w_minus[g]),
      .i_error (w_error[g]),
      .o_seg   (w_seg_new[7*g +: 7])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg      <= 1'b0;
      r_mag      <= '0;
      r_cnt      <= '0;
      r_segs     <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
      for (int i = 0; i < DIGITS; i++) r_dig[i] <= 4'd0;
    end else if (r_state == ST_IDLE) begin
      r_done <= 1'b0;
      if (start) begin
        r_neg <= value[WIDTH-1];
        r_mag <= w_abs;
        r_cnt <= '0;
      end
    end else begin
      r_dig[r_cnt] <= w_rem;
      r_mag        <= w_quot;
      r_cnt        <= r_cnt + CNT_W'(1);
      r_done       <= w_last;
      if (w_last) begin
        r_segs     <= w_seg_new;
        r_overflow <= w_ov;
      end
    end
  end

  assign busy     = (r_state == ST_CONV);
  assign done     = r_done;
  assign overflow = r_overflow;
  assign segs     = display_en ? r_segs : '0;

endmodule

`default_nettype wire

// File: tb/tb_snum_sseg_driver.sv
// tb_snum_sseg_driver: randomized scoreboard bench for snum_sseg_driver (WIDTH=16, DIGITS=4).
// Rev 1.0
`default_nettype none

module tb_snum_sseg_driver;

  localparam int W = 16;
  localparam int D = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   value = '0;
  logic           display_en = 1'b1;
  logic           busy;
  logic           done;
  logic           overflow;
  logic [7*D-1:0] segs;

  snum_sseg_driver #(.WIDTH(W), .DIGITS(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .value      (value),
    .display_en (display_en),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .segs       (segs)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7*D-1:0] segs;
    logic           ov;
    int             cyc;
  } exp_t;

  exp_t           q[$];
  exp_t           mon_e;
  int             n_cmp = 0;
  int             n_err = 0;
  logic [7*D-1:0] last_segs = '0;
  logic [6:0]     code [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h required %h", name, cyc, act, req);
    end
  endtask

  // Decimal rendering from the display rules, using integer arithmetic.
  function automatic exp_t model(input logic [W-1:0] v);
    exp_t e;
    int   iv, m, nd, t;
    iv = int'($signed(v));
    m  = (iv < 0) ? -iv : iv;
    e.segs = '0;
    e.cyc  = 0;
    e.ov   = (iv < 0) ? (m >= 1000) : (m >= 10000);
    if (e.ov) begin
      e.segs[6:0] = 7'h79;
    end else begin
      nd = 1;
      t  = m;
      while (t >= 10) begin t = t / 10; nd++; end
      t = m;
      for (int i = 0; i < nd; i++) begin
        e.segs[7*i +: 7] = code[t % 10];
        t = t / 10;
      end
      if (iv < 0) e.segs[7*nd +: 7] = 7'h40;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done at cycle %0d: got done=1 required done=0", cyc);
      end else begin
        mon_e = q.pop_front();
        check("done_latency", cyc, mon_e.cyc);
        check("overflow", {31'd0, overflow}, {31'd0, mon_e.ov});
        check("segs", {4'd0, segs}, {4'd0, display_en ? mon_e.segs : 28'd0});
        last_segs = mon_e.segs;
      end
    end
  end

  task automatic send(input logic [W-1:0] v);
    exp_t e;
    int   t;
    t = 0;
    @(negedge clk);
    while (busy && t < 20) begin @(negedge clk); t++; end
    if (busy) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got busy=1 required busy=0");
      return;
    end
    start = 1'b1;
    value = v;
    @(posedge clk);
    #1;
    e     = model(v);
    e.cyc = cyc + D;
    q.push_back(e);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy || q.size() != 0) && t < 40) begin @(negedge clk); t++; end
    @(negedge clk);
    check("drain", q.size(), 0);
  endtask

  initial begin
    logic [W-1:0] rv;

    repeat (2) @(negedge clk);
    check("rst_segs", {4'd0, segs}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;

    send(16'd1234);
    wait_idle();
    check("segs_1234", {4'd0, segs}, {4'd0, 7'h06, 7'h5B, 7'h4F, 7'h66});

    // Previous result must stay on the display during conversion.
    send(16'(-42));
    @(negedge clk);
    check("hold_during_conv", {4'd0, segs}, {4'd0, last_segs});
    wait_idle();
    check("segs_m42", {4'd0, segs}, {4'd0, 7'h00, 7'h40, 7'h66, 7'h5B});

    send(16'd0);
    send(16'd9999);
    send(16'd10000);
    send(16'(-999));
    send(16'(-1000));
    send(16'h8000);
    wait_idle();

    // Starts while busy are dropped.
    send(16'd77);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start = 1'b1;
      value = 16'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    display_en = 1'b0;
    @(negedge clk);
    check("disp_off", {4'd0, segs}, 32'd0);
    display_en = 1'b1;
    @(negedge clk);
    check("disp_on", {4'd0, segs}, {4'd0, last_segs});

    // Abandon a conversion with reset.
    send(16'd4321);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_segs", {4'd0, segs}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_ovf", {31'd0, overflow}, 32'd0);
    q.delete();
    last_segs = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      case (i % 3)
        0:       rv = 16'($urandom);
        1:       rv = 16'($urandom_range(0, 2000)) - 16'd1000;
        default: rv = 16'($urandom_range(9990, 10010));
      endcase
      send(rv);
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/snum_sseg_driver.md
SNUM_SSEG_DRIVER -- requirements
Module: snum_sseg_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of the two's-complement input value (range 4..32).
REQ-002 SHALL have parameter DIGITS, default 4, number of seven-segment digit positions (range 2..8).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  conversion request, sampled only in IDLE.
REQ-006 value  input  WIDTH  signed two's-complement number; captured when start is accepted.
REQ-007 display_en  input  1  display enable; low forces segs to all-zero combinationally, conversion unaffected.
REQ-008 busy  output  1  high while a conversion is in progress.
REQ-009 done  output  1  one-cycle pulse marking a segs update.
REQ-010 overflow  output  1  registered; value of last completed conversion did not fit.
REQ-011 segs  output  7*DIGITS  registered patterns; digit i in bits [7i+6:7i], digit 0 rightmost; per digit {g,f,e,d,c,b,a}, active-high.

Function
REQ-012 FSM SHALL have states IDLE and CONV only.
REQ-013 IDLE with start=1 at edge k: capture sign and magnitude |value|, held as WIDTH-bit unsigned so -2^(WIDTH-1) is exact; clear digit counter; go to CONV; busy=1 after edge k.
REQ-014 CONV: each cycle, remainder = magnitude mod 10 to digit slot cnt, magnitude = magnitude / 10, cnt+1; one digit per cycle, LSD first.
REQ-015 At edge k+DIGITS (cnt=DIGITS-1): commit segs and overflow, pulse done, return to IDLE, busy=0; latency start-to-done = DIGITS cycles.
REQ-016 start while busy=1 SHALL be ignored, not queued; start in the done cycle SHALL be accepted (back-to-back).
REQ-017 segs SHALL hold the previous result during CONV, so there is no flicker.
REQ-018 Leading-zero blanking: positions left of the most significant nonzero digit blank (7'h00); value 0 shows "0" in digit 0 only.
REQ-019 Negative: minus (7'h40) in the position immediately left of the most significant digit; other leading positions blank.
REQ-020 overflow=1 when magnitude >= 10^DIGITS (positive) or >= 10^(DIGITS-1) (negative, room for sign).
REQ-021 On overflow, segs SHALL show "E" (7'h79) in digit 0, others blank.
REQ-022 Digit codes 0-9: 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex).
REQ-023 Division by the constant 10 SHALL be combinational per step; no multi-cycle divider.

Reset
REQ-024 rst_n low: state IDLE, busy=0, done=0, overflow=0, segs all zero, counter and magnitude cleared, immediately.
REQ-025 Reset mid-CONV SHALL abandon the conversion; no done pulse after release.
REQ-026 First start after reset release SHALL behave per REQ-013.

Structure
REQ-027 Segment constants (digits, MINUS, BLANK, E) and the state encoding SHALL live in a shared package, sseg_pkg.
REQ-028 Digit-to-pattern encoding SHALL be one sub-module, sseg_encode (4-bit digit + blank/minus/error selects -> 7 bits), instantiated per digit.
REQ-029 Sign/blanking/overflow placement SHALL be computed once at commit from stored digits and leading-zero count.

Verification (WIDTH=16, DIGITS=4)
REQ-030 value=1234, start -> done exactly 4 cycles later; segs digits 3..0 = 06,5B,4F,66; overflow=0.
REQ-031 value=-42 -> digits 3..0 = 00,40,66,5B; value=0 -> 00,00,00,3F.
REQ-032 value=9999 -> 6F x4, overflow=0; value=10000 -> overflow=1, segs = 00,00,00,79; value=-999 -> 40,6F,6F,6F; value=-1000 -> overflow=1; value=-32768 -> overflow=1.
REQ-033 start pulses during busy -> ignored, one done only; start in the done cycle -> second done 4 cycles later.
REQ-034 rst_n low at CONV cycle 2 -> segs=0, busy=0, no done; display_en=0 -> segs=0 while the internal result is retained and reappears when display_en=1.
